// File: rtl/ddr_cmd_pkg.sv
// ddr_cmd_pkg: command encodings and slot geometry shared by the DRAM command pipeline.
package ddr_cmd_pkg;
  localparam int SLOT_WIDTH = 32;
  localparam int SLOT_COUNT = 4;
  localparam int TYPE_WIDTH = 3;
  typedef enum logic [TYPE_WIDTH-1:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_PRE = 3'd2,
    CMD_RD  = 3'd3,
    CMD_WR  = 3'd4,
    CMD_REF = 3'd5,
    CMD_MRS = 3'd6,
    CMD_ZQC = 3'd7
  } cmd_t;
  function automatic logic [2:0] count_rd(input logic [SLOT_COUNT*SLOT_WIDTH-1:0] w);
    count_rd = '0;
    for (int k = 0; k < SLOT_COUNT; k++)
      count_rd += 3'(w[k*SLOT_WIDTH +: TYPE_WIDTH] == CMD_RD);
  endfunction
endpackage

// File: rtl/readback_fifo.sv
// readback_fifo: synchronous FIFO with wrap-bit pointers; head reads as zero while empty.
module readback_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 513
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  assign o_empty = r_wptr == r_rptr;
  assign o_full  = r_wptr == {~r_rptr[AW], r_rptr[AW-1:0]};
  assign o_data  = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (i_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_data;
endmodule

// File: rtl/readback_collector.sv
// readback_collector: counts issued RD commands, buffers PHY read beats, streams them out on AXI-Stream.
// Define READBACK_STATS_EN to add beat/drop/stall counter outputs.
module readback_collector
  import ddr_cmd_pkg::*;
#(
  parameter int INSTR_WIDTH = 128,
  parameter int RDATA_WIDTH = 512,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INSTR_WIDTH-1:0] instr_data,
  input  logic                   instr_valid,
  input  logic [RDATA_WIDTH-1:0] phy_rdata,
  input  logic                   phy_rdata_valid,
  output logic [RDATA_WIDTH-1:0] M_AXIS_RDATA_TDATA,
  output logic                   M_AXIS_RDATA_TVALID,
  input  logic                   M_AXIS_RDATA_TREADY,
  output logic                   M_AXIS_RDATA_TLAST,
  output logic [CNT_WIDTH-1:0]   outstanding,
  output logic                   overflow,
  output logic                   unexpected
`ifdef READBACK_STATS_EN
  ,
  output logic [31:0]            rd_beat_count,
  output logic [31:0]            drop_count,
  output logic [31:0]            stall_cycles
`endif
);
  localparam logic [CNT_WIDTH:0] CNT_MAX = {1'b0, {CNT_WIDTH{1'b1}}};
  logic [CNT_WIDTH-1:0] r_outstanding;
  logic                 r_overflow;
  logic                 r_unexpected;
  logic [2:0]           w_nrd;
  logic                 w_dec;
  logic [CNT_WIDTH:0]   w_sum;
  logic [CNT_WIDTH-1:0] w_next;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [RDATA_WIDTH:0] w_head;
  assign w_nrd  = instr_valid ? count_rd(instr_data) : 3'd0;
  assign w_dec  = phy_rdata_valid && (r_outstanding != '0);
  assign w_sum  = {1'b0, r_outstanding} + (CNT_WIDTH+1)'(w_nrd) - (CNT_WIDTH+1)'(w_dec);
  assign w_next = (w_sum > CNT_MAX) ? CNT_MAX[CNT_WIDTH-1:0] : w_sum[CNT_WIDTH-1:0];
  assign w_pop  = !w_empty && M_AXIS_RDATA_TREADY;
  // A full buffer still accepts a beat when its head leaves in the same cycle.
  assign w_push = phy_rdata_valid && (!w_full || w_pop);
  readback_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RDATA_WIDTH + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({w_dec && (w_next == '0), phy_rdata}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_outstanding <= '0;
      r_overflow    <= 1'b0;
      r_unexpected  <= 1'b0;
    end else begin
      r_outstanding <= w_next;
      if (phy_rdata_valid && !w_push)          r_overflow   <= 1'b1;
      if (phy_rdata_valid && !w_dec)           r_unexpected <= 1'b1;
    end
  assign M_AXIS_RDATA_TVALID = !w_empty;
  assign M_AXIS_RDATA_TDATA  = w_head[RDATA_WIDTH-1:0];
  assign M_AXIS_RDATA_TLAST  = w_head[RDATA_WIDTH];
  assign outstanding         = r_outstanding;
  assign overflow            = r_overflow;
  assign unexpected          = r_unexpected;
`ifdef READBACK_STATS_EN
  logic [31:0] r_beats;
  logic [31:0] r_drops;
  logic [31:0] r_stalls;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_beats  <= '0;
      r_drops  <= '0;
      r_stalls <= '0;
    end else begin
      if (w_push)                                   r_beats  <= r_beats + 32'd1;
      if (phy_rdata_valid && !w_push)               r_drops  <= r_drops + 32'd1;
      if (M_AXIS_RDATA_TVALID && !M_AXIS_RDATA_TREADY) r_stalls <= r_stalls + 32'd1;
    end
  assign rd_beat_count = r_beats;
  assign drop_count    = r_drops;
  assign stall_cycles  = r_stalls;
`endif
endmodule

// File: tb/tb_readback_collector.sv
// tb_readback_collector: directed steps against a behavioural outstanding/occupancy model with a beat scoreboard.
module tb_readback_collector;
  localparam int RW = 512;
  localparam logic [127:0] I_RD1 = 128'h3;
  localparam logic [127:0] I_RD4 = {4{32'h0000_0003}};
  localparam logic [127:0] I_MIX = {32'h0000_0004, 32'h0000_0003, 32'h0000_001B, 32'h0000_0007};
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [127:0]  instr_data = '0;
  logic          instr_valid = 1'b0;
  logic [RW-1:0] phy_rdata = '0;
  logic          phy_rdata_valid = 1'b0;
  logic [RW-1:0] tdata;
  logic          tvalid;
  logic          tready = 1'b1;
  logic          tlast;
  logic [15:0]   outstanding;
  logic          overflow;
  logic          unexpected;
`ifdef READBACK_STATS_EN
  logic [31:0]   rd_beat_count;
  logic [31:0]   drop_count;
  logic [31:0]   stall_cycles;
`endif
  int vectors = 0;
  int miscompares = 0;
  int popped = 0;
  logic [RW:0] sb[$];
  int m_out = 0;
  int m_occ = 0;
  logic m_ovf = 1'b0;
  logic m_unx = 1'b0;

  always #5 clk = ~clk;

  readback_collector dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .instr_data          (instr_data),
    .instr_valid         (instr_valid),
    .phy_rdata           (phy_rdata),
    .phy_rdata_valid     (phy_rdata_valid),
    .M_AXIS_RDATA_TDATA  (tdata),
    .M_AXIS_RDATA_TVALID (tvalid),
    .M_AXIS_RDATA_TREADY (tready),
    .M_AXIS_RDATA_TLAST  (tlast),
    .outstanding         (outstanding),
    .overflow            (overflow),
    .unexpected          (unexpected)
`ifdef READBACK_STATS_EN
    ,
    .rd_beat_count       (rd_beat_count),
    .drop_count          (drop_count),
    .stall_cycles        (stall_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [RW:0] obs, input logic [RW:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nrd_of(input logic [127:0] w);
    int n = 0;
    for (int k = 0; k < 4; k++) if (w[32*k +: 3] == 3'd3) n++;
    return n;
  endfunction

  // One clock of stimulus; the model predicts what the DUT must show after the edge.
  task automatic step(input logic iv, input logic [127:0] iw, input logic bv, input logic [RW-1:0] bd);
    int nxt;
    logic dec, pop;
    instr_valid = iv;
    instr_data = iw;
    phy_rdata_valid = bv;
    phy_rdata = bd;
    dec = bv && m_out > 0;
    nxt = m_out + (iv ? nrd_of(iw) : 0) - int'(dec);
    if (nxt > 65535) nxt = 65535;
    pop = m_occ > 0 && tready;
    if (bv) begin
      if (m_out == 0) m_unx = 1'b1;
      if (m_occ < 16 || pop) begin
        sb.push_back({dec && nxt == 0, bd});
        m_occ++;
      end else m_ovf = 1'b1;
    end
    if (pop) m_occ--;
    m_out = nxt;
    @(posedge clk);
    #1;
    chk("outstanding", RW'(outstanding), RW'(m_out));
    chk("overflow", RW'(overflow), RW'(m_ovf));
    chk("unexpected", RW'(unexpected), RW'(m_unx));
    chk("tvalid", RW'(tvalid), RW'(m_occ != 0));
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0);
  endtask

  task automatic drain(input string tag, input int n);
    int start = popped;
    tready = 1'b1;
    for (int i = 0; i < 40 && sb.size() > 0; i++) idle();
    chk({tag, "_empty"}, RW'(sb.size()), '0);
    chk({tag, "_count"}, RW'(popped - start), RW'(n));
  endtask

  function automatic logic [RW-1:0] pat(input int i);
    return {16{32'hC0DE_0000 + 32'(i)}};
  endfunction

  always @(negedge clk)
    if (rst_n && tvalid && tready) begin
      popped++;
      chk("sb_nonempty", RW'(sb.size() != 0), 1);
      if (sb.size() != 0) chk("beat", {tlast, tdata}, sb.pop_front());
    end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_tvalid", RW'(tvalid), '0);
    chk("rst_tdata", {1'b0, tdata}, '0);
    chk("rst_tlast", RW'(tlast), '0);
    chk("rst_outstanding", RW'(outstanding), '0);
    chk("rst_overflow", RW'(overflow), '0);
    chk("rst_unexpected", RW'(unexpected), '0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // single RD, beat visible one cycle after push with TLAST
    step(1'b1, I_RD1, 1'b0, '0);
    step(1'b0, '0, 1'b1, {64{8'hA5}});
    idle();
    idle();
    // four RD in one word, then a mixed word with two RD slots
    step(1'b1, I_RD4, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, pat(i));
    step(1'b1, I_MIX, 1'b0, '0);
    step(1'b0, '0, 1'b1, pat(10));
    step(1'b1, I_RD1, 1'b1, pat(11));
    step(1'b0, '0, 1'b1, pat(12));
    repeat (3) idle();
    // fill to full, then push and pop in the same cycle
    tready = 1'b0;
    repeat (4) step(1'b1, I_RD4, 1'b0, '0);
    step(1'b1, I_RD1, 1'b0, '0);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, pat(20 + i));
    tready = 1'b1;
    step(1'b0, '0, 1'b1, pat(36));
    tready = 1'b0;
    idle();
    drain("fullpp", 16);
    // overflow: 17 beats with no pops
    tready = 1'b0;
    repeat (4) step(1'b1, I_RD4, 1'b0, '0);
    step(1'b1, I_RD1, 1'b0, '0);
    for (int i = 0; i < 17; i++) step(1'b0, '0, 1'b1, pat(40 + i));
    drain("ovf", 16);
    // unexpected beat with nothing outstanding
    step(1'b0, '0, 1'b1, pat(99));
    repeat (2) idle();
    // asynchronous reset with five beats buffered
    tready = 1'b0;
    step(1'b1, I_RD4, 1'b0, '0);
    step(1'b1, I_RD1, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, pat(60 + i));
    phy_rdata_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tvalid", RW'(tvalid), '0);
    chk("arst_outstanding", RW'(outstanding), '0);
    chk("arst_overflow", RW'(overflow), '0);
    chk("arst_unexpected", RW'(unexpected), '0);
`ifdef READBACK_STATS_EN
    chk("arst_beats", RW'(rd_beat_count), '0);
    chk("arst_drops", RW'(drop_count), '0);
    chk("arst_stalls", RW'(stall_cycles), '0);
`endif
    sb.delete();
    m_out = 0;
    m_occ = 0;
    m_ovf = 1'b0;
    m_unx = 1'b0;
    #2 rst_n = 1'b1;
    tready = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, I_RD1, 1'b0, '0);
    step(1'b0, '0, 1'b1, pat(77));
    repeat (2) idle();
    chk("final_sb_empty", RW'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
